// File: rtl/lane_hit_judge.sv
// Per-lane key-press judge against a falling note window; grades each note and
// keeps a running combo and a combo-weighted score.
module lane_hit_judge #(
  parameter int LANES       = 5,
  parameter int Y_W         = 10,
  parameter int BAR_Y       = 400,
  parameter int BAR_H       = 20,
  parameter int NOTE_H      = 16,
  parameter int PERFECT_TOL = 4,
  parameter int PTS_GOOD    = 50,
  parameter int PTS_PERFECT = 100,
  parameter bit GHOST_BREAK = 1'b1,
  parameter int SCORE_W     = 24,
  parameter int COMBO_W     = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [LANES-1:0]     note_valid,
  input  logic [LANES*Y_W-1:0] note_y,
  input  logic [LANES-1:0]     key,
  output logic [LANES-1:0]     hit,
  output logic [LANES-1:0]     perfect,
  output logic [LANES-1:0]     miss,
  output logic [LANES-1:0]     ghost,
  output logic [COMBO_W-1:0]   combo,
  output logic [SCORE_W-1:0]   score
);

  // Window maths is one bit wider than note_y so note_y+NOTE_H never wraps;
  // centre maths works on doubled rows to keep odd heights exact.
  localparam int XW    = Y_W + 1;
  localparam int CW    = Y_W + 2;
  localparam int CNT_W = $clog2(LANES + 1);
  localparam int PTS_W = 16;
  localparam int ADD_W = PTS_W + 3;

  localparam logic [XW-1:0] BAR_TOP  = XW'(BAR_Y);
  localparam logic [XW-1:0] BAR_END  = XW'(BAR_Y + BAR_H);
  localparam logic [XW-1:0] NOTE_HX  = XW'(NOTE_H);
  localparam logic [CW-1:0] BAR_CTR2 = CW'(2 * BAR_Y + BAR_H);
  localparam logic [CW-1:0] NOTE_HC  = CW'(NOTE_H);
  localparam logic [CW-1:0] TOL2     = CW'(2 * PERFECT_TOL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } lane_state_t;

  logic [LANES-1:0] key_q;
  logic [LANES-1:0] edges;
  logic [LANES-1:0] hit_next;
  logic [LANES-1:0] perfect_next;
  logic [LANES-1:0] miss_next;
  logic [LANES-1:0] ghost_next;

  assign edges = key & ~key_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_q <= '0;
    end else begin
      key_q <= key;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [Y_W-1:0] y;
      logic [XW-1:0]  y_x;
      logic [CW-1:0]  ctr2;
      logic [CW-1:0]  dist2;
      logic           ovl;
      logic           passed;
      logic           centred;
      logic           armed;
      logic           hittable;
      logic           lane_hit;
      logic           lane_miss;
      lane_state_t    state_reg;
      logic           hit_reg;
      logic           perfect_reg;
      logic           miss_reg;
      logic           ghost_reg;

      assign y        = note_y[gi*Y_W +: Y_W];
      assign y_x      = {1'b0, y};
      assign ovl      = (BAR_END > y_x) && (BAR_TOP < (y_x + NOTE_HX));
      assign passed   = (y_x >= BAR_END);
      assign ctr2     = {1'b0, y, 1'b0} + NOTE_HC;
      assign dist2    = (ctr2 >= BAR_CTR2) ? (ctr2 - BAR_CTR2) : (BAR_CTR2 - ctr2);
      assign centred  = (dist2 <= TOL2);

      // A note that has gone invalid is no longer judgeable, even if still ARMED.
      assign armed    = (state_reg == ST_ARMED) && note_valid[gi];
      assign hittable = armed && ovl;
      assign lane_hit  = edges[gi] && hittable;
      assign lane_miss = armed && passed && !lane_hit;

      assign hit_next[gi]     = lane_hit;
      assign perfect_next[gi] = lane_hit && centred;
      assign miss_next[gi]    = lane_miss;
      assign ghost_next[gi]   = edges[gi] && !hittable;

      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg   <= ST_IDLE;
          hit_reg     <= 1'b0;
          perfect_reg <= 1'b0;
          miss_reg    <= 1'b0;
          ghost_reg   <= 1'b0;
        end else begin
          hit_reg     <= lane_hit;
          perfect_reg <= lane_hit && centred;
          miss_reg    <= lane_miss;
          ghost_reg   <= edges[gi] && !hittable;
          case (state_reg)
            ST_IDLE: begin
              if (note_valid[gi]) state_reg <= ST_ARMED;
            end
            ST_ARMED: begin
              if (!note_valid[gi]) begin
                state_reg <= ST_IDLE;
              end else if (lane_hit || lane_miss) begin
                state_reg <= ST_DONE;
              end
            end
            ST_DONE: begin
              if (!note_valid[gi]) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
          endcase
        end
      end

      assign hit[gi]     = hit_reg;
      assign perfect[gi] = perfect_reg;
      assign miss[gi]    = miss_reg;
      assign ghost[gi]   = ghost_reg;
    end
  endgenerate

  logic [CNT_W-1:0]   hit_cnt;
  logic [PTS_W-1:0]   pts_sum;
  logic [2:0]         mult;
  logic [ADD_W-1:0]   add_val;
  logic [SCORE_W:0]   score_sum;
  logic [COMBO_W:0]   combo_sum;
  logic               combo_break;
  logic [COMBO_W-1:0] combo_reg;
  logic [SCORE_W-1:0] score_reg;

  always_comb begin
    hit_cnt = '0;
    pts_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (hit_next[i]) begin
        hit_cnt = hit_cnt + CNT_W'(1);
        pts_sum = pts_sum + (perfect_next[i] ? PTS_W'(PTS_PERFECT) : PTS_W'(PTS_GOOD));
      end
    end
    // Multiplier follows the combo held before this cycle's hits are added.
    if (combo_reg < COMBO_W'(10)) begin
      mult = 3'd1;
    end else if (combo_reg < COMBO_W'(20)) begin
      mult = 3'd2;
    end else if (combo_reg < COMBO_W'(30)) begin
      mult = 3'd3;
    end else begin
      mult = 3'd4;
    end
    add_val     = ADD_W'(mult) * ADD_W'(pts_sum);
    score_sum   = {1'b0, score_reg} + (SCORE_W+1)'(add_val);
    combo_sum   = {1'b0, combo_reg} + (COMBO_W+1)'(hit_cnt);
    combo_break = (|miss_next) || (GHOST_BREAK && (|ghost_next));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      combo_reg <= '0;
      score_reg <= '0;
    end else begin
      score_reg <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      if (combo_break) begin
        combo_reg <= '0;
      end else begin
        combo_reg <= combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
      end
    end
  end

  assign combo = combo_reg;
  assign score = score_reg;

endmodule
